pipe_adder: RTL
===============

Name: pipe_adder

Overview:
Parametrised, pipelined add/subtract unit; successor to the single-bit full_adder. Splits a WIDTH-bit operation into STAGES equal slices. Each slice is added in its own registered stage, and the carry ripples stage to stage. Sits between producers and consumers via valid/ready handshakes and sustains one operation per clock.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline depth = latency in cycles; slice width CHUNK = WIDTH/STAGES; 1..WIDTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock; reset is asynchronous and active-high. Assertion immediately clears all stage valid bits and data registers: out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 after release.
- Reset mid-operation discards every in-flight operation; no partial results appear after release.
- Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
- Sub mode: b_eff=~b, carry_in=~cin. Otherwise b_eff=b, carry_in=cin. sub is captured with the operands.
- Stage k (0..STAGES-1) adds slice k of a and b_eff plus the carry from stage k-1; stage 0 uses carry_in.
- Each stage register holds: valid bit, computed low sum bits, remaining unprocessed high slices of a and b_eff, carry, and the operand sign bits needed for ovf.
- Latency: result visible on sum exactly STAGES cycles after input acceptance, when there is no stall.
- Stage k advances when its next stage is empty or advancing. The last stage advances on out_ready.
- in_ready = !valid[0] || advance[0]; this is combinational from out_ready through the chain.
- Throughput is 1/cycle with out_ready held high. With out_ready low, the pipe fills and holds up to STAGES operations; in_ready drops when full.
- Outputs are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit when full is legal: no bubble is inserted.
- Ordering is strict FIFO; nothing is lost or duplicated.
- Arithmetic (result taken at the final stage):
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
- Result is modulo 2^WIDTH.
- STAGES=1 degenerates to a single registered adder with identical handshake.

Optional Feature:
Macro PIPE_ADDER_SAT_EN.
- Defined:
  - On ovf, sum saturates to 0x7FF..F if a[MSB]=0, else 0x800..0.
  - Adds output port sat (1 bit): 1 when saturation was applied; reset value 0.
  - cout is unchanged.
- Undefined: wrapping result, no sat port.

Decomposition:
- Package pipe_adder_pkg:
  - function chunk_w(WIDTH,STAGES).
  - Typedef of the parametrised stage record: valid, sum_lo, a_hi, b_hi, carry, a_msb, b_msb.
  - Saturation constants as functions of WIDTH.
- Sub-module adder_slice: one CHUNK-wide registered stage with carry in/out and advance/hold control, instantiated STAGES times via generate.

Test Plan:
- Reset: pulse rst high mid-stream with 3 ops in flight -> out_valid=0 and sum=0 immediately; after release, no stale results; in_ready=1.
- Full carry ripple (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Same operands with cin=1 -> 0xFFFD.
- Backpressure: 8 random back-to-back ops, out_ready toggling 1-0-0-1 pattern -> results in order match reference model; in_ready=0 whenever 4 ops held and out_ready=0; outputs stable during stall.
- PIPE_ADDER_SAT_EN defined: a=0x7FFF+0x0001 -> sum=0x7FFF, sat=1; a=0x8000 - b=0x0001 (sub) -> sum=0x8000, sat=1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// PIPE_ADDER_SAT_EN enables the saturation constants' use in pipe_adder.
package pipe_adder_pkg;

    // Per-stage control record; the WIDTH-dependent fields (sum_lo, a_hi, b_hi)
    // travel beside it as full-width vectors so the record stays parameter-free.
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_ctrl_t;

    localparam int unsigned MaxWidth = 128;

    function automatic int unsigned chunk_w(int unsigned width, int unsigned stages);
        return width / stages;
    endfunction

    function automatic logic [MaxWidth-1:0] sat_neg(int unsigned width);
        logic [MaxWidth-1:0] one;
        one = {{(MaxWidth-1){1'b0}}, 1'b1};
        return one << (width - 1);
    endfunction

    function automatic logic [MaxWidth-1:0] sat_pos(int unsigned width);
        logic [MaxWidth-1:0] one;
        one = {{(MaxWidth-1){1'b0}}, 1'b1};
        return (one << (width - 1)) - one;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered pipeline stage: adds slice Idx of the operands plus the incoming
// carry, and carries the operands and partial sum forward. Holds when load_i is low.
module adder_slice import pipe_adder_pkg::*; #(
    parameter int unsigned Width = 16,
    parameter int unsigned Chunk = 4,
    parameter int unsigned Idx   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  stage_ctrl_t       ctrl_i,
    input  logic [Width-1:0]  a_i,
    input  logic [Width-1:0]  b_i,
    input  logic [Width-1:0]  sum_i,
    output stage_ctrl_t       ctrl_o,
    output logic [Width-1:0]  a_o,
    output logic [Width-1:0]  b_o,
    output logic [Width-1:0]  sum_o
);

    localparam int unsigned Lsb = Idx * Chunk;

    logic [Chunk:0]   add_res;
    logic [Width-1:0] sum_d;
    stage_ctrl_t      ctrl_q;
    logic [Width-1:0] a_q, b_q, sum_q;

    always_comb begin
        add_res = {1'b0, a_i[Lsb +: Chunk]} + {1'b0, b_i[Lsb +: Chunk]}
                + {{Chunk{1'b0}}, ctrl_i.carry};
        sum_d = sum_i;
        sum_d[Lsb +: Chunk] = add_res[Chunk-1:0];
    end

    // Bubbles only clear the valid bit so data registers keep their last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
        end else if (load_i) begin
            ctrl_q.valid <= ctrl_i.valid;
            if (ctrl_i.valid) begin
                ctrl_q.carry <= add_res[Chunk];
                ctrl_q.a_msb <= ctrl_i.a_msb;
                ctrl_q.b_msb <= ctrl_i.b_msb;
                a_q          <= a_i;
                b_q          <= b_i;
                sum_q        <= sum_d;
            end
        end
    end

    assign ctrl_o = ctrl_q;
    assign a_o    = a_q;
    assign b_o    = b_q;
    assign sum_o  = sum_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides, STAGES slices.
// Define PIPE_ADDER_SAT_EN to saturate on signed overflow and expose the sat port.
module pipe_adder import pipe_adder_pkg::*; #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef PIPE_ADDER_SAT_EN
    output logic             ovf,
    output logic             sat
`else
    output logic             ovf
`endif
);

    localparam int unsigned Chunk = chunk_w(WIDTH, STAGES);

    stage_ctrl_t      ctrl   [STAGES+1];
    logic [WIDTH-1:0] a_st   [STAGES+1];
    logic [WIDTH-1:0] b_st   [STAGES+1];
    logic [WIDTH-1:0] sum_st [STAGES+1];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  b_eff;
    logic              carry_in;

    assign b_eff    = sub ? ~b : b;
    assign carry_in = sub ? ~cin : cin;

    assign ctrl[0]   = '{valid: in_valid, carry: carry_in, a_msb: a[WIDTH-1],
                         b_msb: b_eff[WIDTH-1]};
    assign a_st[0]   = a;
    assign b_st[0]   = b_eff;
    assign sum_st[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign vld[k] = ctrl[k+1].valid;
        // Stage k may load when some stage at or beyond it has a free slot.
        assign load[k] = out_ready || !(&vld[STAGES-1:k]);

        adder_slice #(
            .Width (WIDTH),
            .Chunk (Chunk),
            .Idx   (k)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[k]),
            .ctrl_i (ctrl[k]),
            .a_i    (a_st[k]),
            .b_i    (b_st[k]),
            .sum_i  (sum_st[k]),
            .ctrl_o (ctrl[k+1]),
            .a_o    (a_st[k+1]),
            .b_o    (b_st[k+1]),
            .sum_o  (sum_st[k+1])
        );
    end

    assign in_ready = load[0];

    logic [WIDTH-1:0] sum_raw;
    logic             ovf_raw;
    stage_ctrl_t      last;

    assign last      = ctrl[STAGES];
    assign sum_raw   = sum_st[STAGES];
    assign out_valid = last.valid;
    assign cout      = last.carry;
    assign ovf_raw   = (last.a_msb == last.b_msb) && (sum_raw[WIDTH-1] != last.a_msb);
    assign ovf       = ovf_raw;

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [MaxWidth-1:0] SatPosFull = sat_pos(WIDTH);
    localparam logic [MaxWidth-1:0] SatNegFull = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0]    SatPos     = SatPosFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SatNeg     = SatNegFull[WIDTH-1:0];

    assign sum = ovf_raw ? (last.a_msb ? SatNeg : SatPos) : sum_raw;
    assign sat = ovf_raw;
`else
    assign sum = sum_raw;
`endif

    // Operands are fully consumed by the last slice.
    logic unused_ops;
    assign unused_ops = ^{a_st[STAGES], b_st[STAGES]};

endmodule
